// File: rtl/fractal_pkg.sv
// Shared encodings for the escape-time fractal engine.
package fractal_pkg;

  // Per-pixel control sequence: latch/prepare, iterate, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_ITER = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam logic MODE_JULIA  = 1'b0;
  localparam logic MODE_MANDEL = 1'b1;

  // Squared escape radius (|z|^2 > 4) expressed at the scale of a full
  // product of two FRAC-bit fixed-point operands, i.e. 2^(2*FRAC).
  function automatic logic [63:0] esc_radius2(input int frac);
    return 64'd4 << (2 * frac);
  endfunction

endpackage

// File: rtl/fractal_iter_datapath.sv
// Combinational step of z <- z^2 + c plus the escape test on the current z.
module fractal_iter_datapath
  import fractal_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] z_re_i,
  input  logic signed [WIDTH-1:0] z_im_i,
  input  logic signed [WIDTH-1:0] c_re_i,
  input  logic signed [WIDTH-1:0] c_im_i,
  output logic                    escape_o,
  output logic signed [WIDTH-1:0] z_re_o,
  output logic signed [WIDTH-1:0] z_im_o
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = PW + 1;
  localparam logic signed [EW-1:0] ESC_R2 = EW'(esc_radius2(FRAC));

  logic signed [PW-1:0] zr_w, zi_w;
  logic signed [PW-1:0] rr, ii, ri;
  logic signed [EW-1:0] mag2;

  // Full-width products; one extra bit on the magnitude so the sum of two
  // squares can never wrap, and the compare needs no rescaling.
  assign zr_w = PW'(z_re_i);
  assign zi_w = PW'(z_im_i);
  assign rr   = zr_w * zr_w;
  assign ii   = zi_w * zi_w;
  assign ri   = zr_w * zi_w;
  assign mag2 = EW'(rr) + EW'(ii);

  assign escape_o = mag2 > ESC_R2;

  // Shift by FRAC-1 on the cross term folds in the factor of two of 2*zr*zi.
  assign z_re_o = WIDTH'((rr - ii) >>> FRAC) + c_re_i;
  assign z_im_o = WIDTH'(ri >>> (FRAC - 1)) + c_im_i;

endmodule

// File: rtl/fractal_escape_engine.sv
// Raster-order escape-time fractal generator: one iteration count per pixel
// on a valid/ready stream with frame/line sideband.
module fractal_escape_engine
  import fractal_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 8,
  parameter int ITER_W = 8,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  localparam int XW    = $clog2(X_SIZE),
  localparam int YW    = $clog2(Y_SIZE)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_enable,
  input  logic                    cfg_mode,
  input  logic [ITER_W-1:0]       cfg_max_iter,
  input  logic signed [WIDTH-1:0] cfg_re_min,
  input  logic signed [WIDTH-1:0] cfg_im_min,
  input  logic signed [WIDTH-1:0] cfg_re_step,
  input  logic signed [WIDTH-1:0] cfg_im_step,
  input  logic signed [WIDTH-1:0] cfg_c_re,
  input  logic signed [WIDTH-1:0] cfg_c_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ITER_W-1:0]       m_iter,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic [XW-1:0]           m_x,
  output logic [YW-1:0]           m_y,
  output logic                    busy
);

  // Frame-constant configuration; im_min is only needed at the latch itself.
  typedef struct packed {
    logic                    mode;
    logic [ITER_W-1:0]       max_iter;
    logic signed [WIDTH-1:0] re_min;
    logic signed [WIDTH-1:0] re_step;
    logic signed [WIDTH-1:0] im_step;
    logic signed [WIDTH-1:0] c_re;
    logic signed [WIDTH-1:0] c_im;
  } shadow_t;

  state_e                  state_q, state_d;
  shadow_t                 shadow_q, shadow_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic signed [WIDTH-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
  logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic signed [WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic [ITER_W-1:0]       m_iter_q, m_iter_d;

  logic                    latch;
  logic                    at_eol, at_eof;
  logic                    esc;
  logic signed [WIDTH-1:0] nz_re, nz_im;

  fractal_iter_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_dp (
    .z_re_i   (z_re_q),
    .z_im_i   (z_im_q),
    .c_re_i   (c_re_q),
    .c_im_i   (c_im_q),
    .escape_o (esc),
    .z_re_o   (nz_re),
    .z_im_o   (nz_im)
  );

  assign at_eol = (x_q == XW'(X_SIZE - 1));
  assign at_eof = at_eol && (y_q == YW'(Y_SIZE - 1));

  // Next-state and datapath register updates for the pixel sequencer.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    x_d      = x_q;
    y_d      = y_q;
    p_re_d   = p_re_q;
    p_im_d   = p_im_q;
    z_re_d   = z_re_q;
    z_im_d   = z_im_q;
    c_re_d   = c_re_q;
    c_im_d   = c_im_q;
    iter_d   = iter_q;
    m_iter_d = m_iter_q;
    latch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          latch   = 1'b1;
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        if (shadow_q.mode == MODE_MANDEL) begin
          z_re_d = '0;
          z_im_d = '0;
          c_re_d = p_re_q;
          c_im_d = p_im_q;
        end else begin
          z_re_d = p_re_q;
          z_im_d = p_im_q;
          c_re_d = shadow_q.c_re;
          c_im_d = shadow_q.c_im;
        end
        iter_d  = '0;
        state_d = ST_ITER;
      end

      ST_ITER: begin
        // The cap is checked before stepping, so iter never exceeds max_iter
        // and a cap of zero reports zero without touching z.
        if (esc || (iter_q == shadow_q.max_iter)) begin
          m_iter_d = iter_q;
          state_d  = ST_OUT;
        end else begin
          z_re_d = nz_re;
          z_im_d = nz_im;
          iter_d = iter_q + ITER_W'(1);
        end
      end

      ST_OUT: begin
        // Coordinates and pixel point move only on an accepted beat.
        if (m_ready) begin
          state_d = ST_INIT;
          if (at_eol) begin
            x_d    = '0;
            p_re_d = shadow_q.re_min;
            if (at_eof) begin
              y_d = '0;
              if (cfg_enable) latch   = 1'b1;
              else            state_d = ST_IDLE;
            end else begin
              y_d    = y_q + YW'(1);
              p_im_d = p_im_q + shadow_q.im_step;
            end
          end else begin
            x_d    = x_q + XW'(1);
            p_re_d = p_re_q + shadow_q.re_step;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame-start snapshot; overrides any pixel-point update made above.
    if (latch) begin
      shadow_d.mode     = cfg_mode;
      shadow_d.max_iter = cfg_max_iter;
      shadow_d.re_min   = cfg_re_min;
      shadow_d.re_step  = cfg_re_step;
      shadow_d.im_step  = cfg_im_step;
      shadow_d.c_re     = cfg_c_re;
      shadow_d.c_im     = cfg_c_im;
      p_re_d            = cfg_re_min;
      p_im_d            = cfg_im_min;
    end
  end

  // State and datapath registers; reset drops any pixel in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_re_q   <= '0;
      p_im_q   <= '0;
      z_re_q   <= '0;
      z_im_q   <= '0;
      c_re_q   <= '0;
      c_im_q   <= '0;
      iter_q   <= '0;
      m_iter_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_re_q   <= p_re_d;
      p_im_q   <= p_im_d;
      z_re_q   <= z_re_d;
      z_im_q   <= z_im_d;
      c_re_q   <= c_re_d;
      c_im_q   <= c_im_d;
      iter_q   <= iter_d;
      m_iter_q <= m_iter_d;
    end
  end

  assign m_valid = (state_q == ST_OUT);
  assign busy    = (state_q != ST_IDLE);
  assign m_iter  = m_iter_q;
  assign m_x     = x_q;
  assign m_y     = y_q;
  assign m_sof   = m_valid && (x_q == '0) && (y_q == '0);
  assign m_eol   = m_valid && at_eol;

endmodule

// File: tb/tb_fractal_escape_engine.sv
// Self-checking bench: reference escape-time model vs. streamed pixel results.
module tb_fractal_escape_engine;

  localparam int WIDTH  = 32;
  localparam int FRAC   = 8;
  localparam int ITER_W = 8;
  localparam int X_SIZE = 4;
  localparam int Y_SIZE = 2;
  localparam int XW     = $clog2(X_SIZE);
  localparam int YW     = $clog2(Y_SIZE);
  localparam int NPIX   = X_SIZE * Y_SIZE;
  localparam int BUDGET = 600;

  typedef struct {
    bit mode;
    bit en;
    int max_iter;
    int re_min;
    int im_min;
    int re_step;
    int im_step;
    int c_re;
    int c_im;
  } cfg_t;

  logic                    aclk;
  logic                    areset;
  logic                    cfg_enable;
  logic                    cfg_mode;
  logic [ITER_W-1:0]       cfg_max_iter;
  logic signed [WIDTH-1:0] cfg_re_min, cfg_im_min, cfg_re_step, cfg_im_step;
  logic signed [WIDTH-1:0] cfg_c_re, cfg_c_im;
  logic                    m_valid, m_ready, m_sof, m_eol, busy;
  logic [ITER_W-1:0]       m_iter;
  logic [XW-1:0]           m_x;
  logic [YW-1:0]           m_y;

  int n_chk, n_err;

  fractal_escape_engine #(
    .WIDTH  (WIDTH),
    .FRAC   (FRAC),
    .ITER_W (ITER_W),
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_enable   (cfg_enable),
    .cfg_mode     (cfg_mode),
    .cfg_max_iter (cfg_max_iter),
    .cfg_re_min   (cfg_re_min),
    .cfg_im_min   (cfg_im_min),
    .cfg_re_step  (cfg_re_step),
    .cfg_im_step  (cfg_im_step),
    .cfg_c_re     (cfg_c_re),
    .cfg_c_im     (cfg_c_im),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_iter       (m_iter),
    .m_sof        (m_sof),
    .m_eol        (m_eol),
    .m_x          (m_x),
    .m_y          (m_y),
    .busy         (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Escape-time count straight from the maths: pixel point by multiplication,
  // z^2 + c in 64-bit integers, each new component wrapped to 32 bits.
  function automatic int ref_iter(cfg_t c, int x, int y);
    int     pr, pi;
    longint zr, zi, cr, ci, rr, ii, tr, ti;
    pr = c.re_min + x * c.re_step;
    pi = c.im_min + y * c.im_step;
    if (c.mode) begin
      zr = 0;  zi = 0;  cr = pr;     ci = pi;
    end else begin
      zr = pr; zi = pi; cr = c.c_re; ci = c.c_im;
    end
    for (int n = 0; n < 256; n++) begin
      rr = zr * zr;
      ii = zi * zi;
      if ((rr + ii) > (64'sd4 << (2 * FRAC)) || n == c.max_iter) return n;
      tr = ((rr - ii) >>> FRAC) + cr;
      ti = ((zr * zi) >>> (FRAC - 1)) + ci;
      zr = longint'(int'(tr));
      zi = longint'(int'(ti));
    end
    return -1;
  endfunction

  task automatic drive(input cfg_t c);
    cfg_enable   = c.en;
    cfg_mode     = c.mode;
    cfg_max_iter = ITER_W'(c.max_iter);
    cfg_re_min   = c.re_min;
    cfg_im_min   = c.im_min;
    cfg_re_step  = c.re_step;
    cfg_im_step  = c.im_step;
    cfg_c_re     = c.c_re;
    cfg_c_im     = c.c_im;
  endtask

  // Start a frame from IDLE; returns at the first negedge with the DUT in INIT.
  task automatic launch(input cfg_t c);
    drive(c);
    cfg_enable = 1'b1;
    @(negedge aclk);
    chk("busy_start", busy, 1);
    cfg_enable = c.en;
  endtask

  // Consume one frame; must be entered with the DUT in INIT of pixel 0.
  task automatic run_frame(input cfg_t c, input int swap_at, input cfg_t nxt,
                           input int stall_at, input int stall_len,
                           output int first_iter);
    int bx, by, e, lat;
    first_iter = -1;
    for (int b = 0; b < NPIX; b++) begin
      if (b == swap_at) drive(nxt);
      bx  = b % X_SIZE;
      by  = b / X_SIZE;
      e   = ref_iter(c, bx, by);
      lat = 0;
      while (!m_valid && lat < BUDGET) begin
        @(negedge aclk);
        lat++;
      end
      chk("valid", m_valid, 1);
      chk("iter", m_iter, e);
      chk("latency", lat, e + 2);
      chk("x", m_x, bx);
      chk("y", m_y, by);
      chk("sof", m_sof, b == 0);
      chk("eol", m_eol, bx == X_SIZE - 1);
      if (b == 0) first_iter = int'(m_iter);
      if (b == stall_at) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge aclk);
          chk("stall_valid", m_valid, 1);
          chk("stall_iter", m_iter, e);
          chk("stall_x", m_x, bx);
          chk("stall_y", m_y, by);
          chk("stall_sof", m_sof, b == 0);
        end
        m_ready = 1'b1;
      end
      @(negedge aclk);
      chk("one_beat", m_valid, 0);
    end
  endtask

  initial begin
    cfg_t ca, cb, cc, cr, cm, cj, cz, zero;
    int   fi;
    n_chk = 0;
    n_err = 0;
    zero  = '{mode:0, en:0, max_iter:0, re_min:0, im_min:0, re_step:0,
              im_step:0, c_re:0, c_im:0};
    drive(zero);
    m_ready = 1'b1;
    areset  = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", m_x, 0);
    chk("rst_y", m_y, 0);
    chk("rst_iter", m_iter, 0);

    // Mandelbrot near origin: cap of 100, first pixel stalled for 10 cycles;
    // max_iter drops to 5 mid-frame and must only apply to the next frame.
    ca = '{mode:1, en:1, max_iter:100, re_min:0, im_min:0, re_step:1,
           im_step:1, c_re:0, c_im:0};
    cb = ca; cb.max_iter = 5;
    cc = cb; cc.en = 1'b0;
    launch(ca);
    run_frame(ca, 3, cb, 0, 10, fi);
    chk("origin_iter", fi, 100);
    chk("chain_busy", busy, 1);
    run_frame(cb, 4, cc, -1, 0, fi);
    chk("cap5_iter", fi, 5);
    chk("end_idle", busy, 0);

    // Reset while iterating.
    cr = ca; cr.max_iter = 200;
    launch(cr);
    repeat (30) @(negedge aclk);
    chk("mid_busy", busy, 1);
    areset     = 1'b1;
    cfg_enable = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_x", m_x, 0);
    chk("mrst_y", m_y, 0);
    chk("mrst_iter", m_iter, 0);

    // Mandelbrot at 2.5: escapes after one step.
    cm = '{mode:1, en:0, max_iter:50, re_min:640, im_min:0, re_step:64,
           im_step:32, c_re:0, c_im:0};
    launch(cm);
    run_frame(cm, -1, cm, -1, 0, fi);
    chk("mandel_2p5", fi, 1);
    chk("m_idle", busy, 0);

    // Julia at -3.0: escapes immediately.
    cj = '{mode:0, en:0, max_iter:30, re_min:-768, im_min:0, re_step:100,
           im_step:50, c_re:-200, c_im:100};
    launch(cj);
    run_frame(cj, -1, cj, -1, 0, fi);
    chk("julia_m3", fi, 0);

    // Zero cap.
    cz = '{mode:0, en:0, max_iter:0, re_min:10, im_min:10, re_step:20,
           im_step:20, c_re:0, c_im:0};
    launch(cz);
    run_frame(cz, -1, cz, -1, 0, fi);
    chk("cap0_iter", fi, 0);

    // Randomized viewports, modes, caps and stalls.
    for (int r = 0; r < 6; r++) begin
      cr.mode     = 1'($urandom_range(1));
      cr.en       = 1'b0;
      cr.max_iter = int'($urandom_range(40));
      cr.re_min   = int'($urandom_range(1000)) - 500;
      cr.im_min   = int'($urandom_range(1000)) - 500;
      cr.re_step  = int'($urandom_range(300)) - 150;
      cr.im_step  = int'($urandom_range(300)) - 150;
      cr.c_re     = int'($urandom_range(600)) - 300;
      cr.c_im     = int'($urandom_range(600)) - 300;
      launch(cr);
      run_frame(cr, -1, cr, int'($urandom_range(NPIX - 1)),
                int'($urandom_range(4)), fi);
      chk("rand_idle", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
